// File: rtl/hex_rotation_reader.sv
// Display-bus monitor for the rotating "dE10" seven-segment writer.
// Decodes each active-low bus back to a nibble and tracks the rotation with a search/track/lock FSM.
module hex_rotation_reader #(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  input  logic [6:0] hex2,
  input  logic [6:0] hex3,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] seg_valid,
  output logic       frame_change,
  output logic       word_ok,
  output logic [1:0] phase,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_e;

  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] LOCK_CNT  = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_LIM  = 4'(MISS_LIMIT);

  // Returns {legal, nibble}; anything outside the sixteen glyphs decodes as illegal zero.
  function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
    logic [4:0] dec;
    case (seg)
      7'h40:   dec = {1'b1, 4'h0};
      7'h79:   dec = {1'b1, 4'h1};
      7'h24:   dec = {1'b1, 4'h2};
      7'h30:   dec = {1'b1, 4'h3};
      7'h19:   dec = {1'b1, 4'h4};
      7'h12:   dec = {1'b1, 4'h5};
      7'h02:   dec = {1'b1, 4'h6};
      7'h78:   dec = {1'b1, 4'h7};
      7'h00:   dec = {1'b1, 4'h8};
      7'h10:   dec = {1'b1, 4'h9};
      7'h08:   dec = {1'b1, 4'hA};
      7'h03:   dec = {1'b1, 4'hB};
      7'h46:   dec = {1'b1, 4'hC};
      7'h21:   dec = {1'b1, 4'hD};
      7'h06:   dec = {1'b1, 4'hE};
      7'h0E:   dec = {1'b1, 4'hF};
      default: dec = 5'b0;
    endcase
    return dec;
  endfunction

  logic [3:0][6:0] curHex_q, prevHex_q;
  logic [3:0][3:0] digit_q, digit_d;
  logic [3:0]      segValid_q, segValid_d;
  logic            frameChg_q, wordOk_q, err_q;
  logic [7:0]      errCnt_q, errCnt_d;
  state_e          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [3:0]      matchCnt_q, matchCnt_d;
  logic [3:0]      missCnt_q, missCnt_d;

  logic [3:0] matchVec;
  logic       wordOkNow;
  logic [1:0] pNow;
  logic       curChanged;
  logic       errPulse;
  logic [1:0] phaseNext;
  logic       inStep;

  // Blank reset value makes the first non-blank input register as a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curHex_q  <= {4{SEG_BLANK}};
      prevHex_q <= {4{SEG_BLANK}};
    end else begin
      curHex_q  <= {hex3, hex2, hex1, hex0};
      prevHex_q <= curHex_q;
    end
  end

  always_comb begin
    digit_d    = '0;
    segValid_d = '0;
    matchVec   = '0;
    pNow       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      logic [4:0] dec;
      dec           = decodeSeg(curHex_q[i]);
      digit_d[i]    = dec[3:0];
      segValid_d[i] = dec[4];
    end
    for (int p = 0; p < 4; p++) begin
      matchVec[p] = (curHex_q[2'(p)]     == SEG_D) &&
                    (curHex_q[2'(p + 1)] == SEG_E) &&
                    (curHex_q[2'(p + 2)] == SEG_1) &&
                    (curHex_q[2'(p + 3)] == SEG_0);
      if (matchVec[p]) pNow = 2'(p);
    end
    wordOkNow  = $onehot(matchVec);
    curChanged = (curHex_q != prevHex_q);
    phaseNext  = phase_q + 2'd1;
    inStep     = wordOkNow && (pNow == phaseNext);
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    matchCnt_d = matchCnt_q;
    missCnt_d  = missCnt_q;
    errPulse   = 1'b0;
    if (curChanged) begin
      case (state_q)
        SEARCH: begin
          if (wordOkNow) begin
            phase_d    = pNow;
            matchCnt_d = 4'd1;
            missCnt_d  = 4'd0;
            state_d    = (LOCK_CNT == 4'd1) ? LOCKED : TRACK;
          end
        end
        TRACK: begin
          if (inStep) begin
            phase_d    = pNow;
            matchCnt_d = matchCnt_q + 4'd1;
            if ((matchCnt_q + 4'd1) >= LOCK_CNT) begin
              state_d   = LOCKED;
              missCnt_d = 4'd0;
            end
          end else begin
            errPulse = 1'b1;
            if (wordOkNow) begin
              phase_d    = pNow;
              matchCnt_d = 4'd1;
            end else begin
              state_d    = SEARCH;
              matchCnt_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          if (inStep) begin
            phase_d   = pNow;
            missCnt_d = 4'd0;
          end else begin
            // Flywheel: keep advancing the expected phase through a bad frame.
            errPulse  = 1'b1;
            phase_d   = phaseNext;
            missCnt_d = missCnt_q + 4'd1;
            if ((missCnt_q + 4'd1) >= MISS_LIM) begin
              state_d    = SEARCH;
              matchCnt_d = 4'd0;
              missCnt_d  = 4'd0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    errCnt_d = (errPulse && (errCnt_q != 8'hFF)) ? errCnt_q + 8'd1 : errCnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q    <= '0;
      segValid_q <= '0;
      frameChg_q <= 1'b0;
      wordOk_q   <= 1'b0;
      err_q      <= 1'b0;
      errCnt_q   <= 8'd0;
      state_q    <= SEARCH;
      phase_q    <= 2'd0;
      matchCnt_q <= 4'd0;
      missCnt_q  <= 4'd0;
    end else begin
      digit_q    <= digit_d;
      segValid_q <= segValid_d;
      frameChg_q <= curChanged;
      wordOk_q   <= wordOkNow;
      err_q      <= errPulse;
      errCnt_q   <= errCnt_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      matchCnt_q <= matchCnt_d;
      missCnt_q  <= missCnt_d;
    end
  end

  assign digit0       = digit_q[0];
  assign digit1       = digit_q[1];
  assign digit2       = digit_q[2];
  assign digit3       = digit_q[3];
  assign seg_valid    = segValid_q;
  assign frame_change = frameChg_q;
  assign word_ok      = wordOk_q;
  assign phase        = phase_q;
  assign locked       = (state_q == LOCKED);
  assign err          = err_q;
  assign err_count    = errCnt_q;

endmodule

// File: doc/hex_rotation_reader.md
# hex_rotation_reader

Monitor and decoder for the four-digit seven-segment bus (hex0..hex3) driven by the rotating "dE10" display writers. Samples the four active-low segment buses every clock, decodes each back to a hex nibble, and tracks the rotating word with a search/track/lock state machine. Reports rotation phase, lock status and errors. Used on-board as a loopback checker and in simulation as a display-bus monitor.

## Interface
- LOCK_COUNT, 3, consecutive correctly phased frames needed to assert lock; legal range 1..15
- MISS_LIMIT, 2, consecutive mismatched frames in LOCKED that drop lock; legal range 1..15
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset; asynchronous and active-low
- hex0, hex1, hex2, hex3  in  7 each  segment buses, active-low, bit 6..0 = g..a
- digit0, digit1, digit2, digit3  out  4 each  decoded nibble per display
- seg_valid  out  4  bit i = hexi holds a legal glyph
- frame_change  out  1  one-cycle pulse when any bus changed
- word_ok  out  1  current frame is the word at some phase
- phase  out  2  index of the display showing 'd'
- locked  out  1  rotation lock
- err  out  1  one-cycle pulse on a mismatched frame while TRACK or LOCKED
- err_count  out  8  saturating error count

## Operation
- Decode table, active-low gfedcba: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex). Any other pattern, including blank 7F, gives digit=0 and seg_valid bit=0.
- Word at phase p: hex[p]=d(21), hex[(p+1)%4]=E(06), hex[(p+2)%4]=1(79), hex[(p+3)%4]=0(40). word_ok=1 iff exactly one p matches, and that p is the frame phase.
- Sample registers: cur[0..3] <= hex inputs; prev <= cur. A frame is evaluated only when cur != prev.
- FSM states: SEARCH, TRACK, LOCKED. Internal match_cnt and miss_cnt are 4 bits each.
- SEARCH: on a frame with word_ok, go to TRACK with phase=p and match_cnt=1. If LOCK_COUNT=1, go directly to LOCKED. Other frames: stay, no err.
- TRACK: on a frame with word_ok and p == phase+1 (mod 4), set phase=p and match_cnt++. Reaching LOCK_COUNT goes to LOCKED with miss_cnt=0.
- TRACK mismatch: err pulse, err_count++. If the frame has word_ok, re-acquire: phase=p, match_cnt=1, stay in TRACK. Otherwise go to SEARCH.
- LOCKED match (word_ok and p == phase+1): phase=p, miss_cnt=0.
- LOCKED mismatch: err pulse, err_count++, phase=phase+1 (flywheel), miss_cnt++. When miss_cnt reaches MISS_LIMIT: go to SEARCH, locked=0.
- locked=1 exactly while the state is LOCKED.
- err_count saturates at 255 and clears only on reset.
- Frames with no change (cur == prev) do not advance phase or any counter.

## Timing
- Reset values: digit0..3=0, seg_valid=0, frame_change=0, word_ok=0, phase=0, locked=0, err=0, err_count=0, state SEARCH, match_cnt=0, miss_cnt=0.
- cur and prev reset to 7F on every bus, so the first non-blank input counts as a change.
- Input stable before edge N is captured in cur at edge N. digit, seg_valid, word_ok, frame_change, err, phase, locked and the state all update at edge N+1. Latency is 2 edges from input to outputs.
- frame_change and err are registered single-cycle pulses. Back-to-back frames (inputs changing every cycle, as the writer does) give frame_change high continuously, one evaluation per cycle.
- The LOCKED decision uses the same edge as the frame_change assertion, so locked rises on the edge frame_change reports the LOCK_COUNT-th good frame.
- rst_n deassertion mid-rotation restarts in SEARCH. Acquisition restarts from the first sampled frame.
- An async reset mid-frame clears all outputs immediately, without waiting for clk.

## Test plan
- Reset: hold rst_n=0 with random buses -> all outputs 0. Release with hex0..3=7F -> no frame_change, state SEARCH.
- Static decode: hex0=21, hex1=06, hex2=79, hex3=40 held -> two edges later digit0..3=D,E,1,0, seg_valid=F, word_ok=1, phase=0, frame_change for one cycle only, locked stays 0.
- Rotation lock: drive phases 0,1,2,3,0… one per cycle (defaults) -> locked=1 on the edge reporting the third frame, phase follows input two edges late, err never asserted over 100 cycles.
- Glitch tolerance: while locked, substitute one frame with hex2=7F -> err pulse, err_count=1, locked stays 1, phase flywheels. The next correct frame clears miss_cnt.
- Loss of lock: while locked, freeze the phase-pattern wrong twice (e.g. phase sequence 1,3,1) -> two err pulses, locked=0 after the second, re-lock after 3 good frames, err_count=2.
- Saturation and reverse rotation: rotate with phase decreasing (3,2,1,0…) -> never locks, err pulses each frame after acquisition, err_count stops at 255.
